pad_input_conditioner: RTL and testbench

// - Input-side conditioning between io_pad_i[15:0] and the SoC UART RX / GPIO inputs.
// - Synchronises all pads; debounces GPIO pads with a shared tick prescaler.
// - UART RX pad(s) are synchronised only, never debounced.
// - Optional sticky any-edge capture with maskable interrupt.

---
 rtl/pad_cond_pkg.sv | 21 ++
 rtl/pad_debounce_bit.sv | 60 ++++++
 rtl/pad_input_conditioner.sv | 148 ++++++++++++++
 tb/tb_pad_input_conditioner.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_cond_pkg.sv
// -----------------------------------------------------------------------------
// pad_cond_pkg
// Shared types and constants for the pad input conditioner slice.
//   pad_vec_t      : one bit per pad (16 pads)
//   PAD_UART_PIN   : pad index carrying UART RX
//   PAD_RESET_VAL  : filtered pad value at reset/disable (UART idle high)
//   db_cnt_width() : width of a per-pad debounce counter for a given DB_COUNT
// -----------------------------------------------------------------------------
package pad_cond_pkg;

  typedef logic [15:0] pad_vec_t;

  localparam int unsigned PAD_UART_PIN  = 0;
  localparam pad_vec_t    PAD_RESET_VAL = 16'h0001;

  // The counter only ever holds 0..DB_COUNT-1, so this is never too narrow.
  function automatic int unsigned db_cnt_width(input int unsigned db_count);
    return $clog2(db_count + 1);
  endfunction

endpackage

// File: rtl/pad_debounce_bit.sv
// -----------------------------------------------------------------------------
// pad_debounce_bit
// Debounce filter for one synchronised pad. A new level is accepted only after
// it has differed from the current filtered level on DB_COUNT consecutive
// prescaler ticks; any cycle where the two agree restarts the count. Bypass
// pads follow the synchronised level every cycle.
// Ports:
//   sys_clk, rst_n : clock, asynchronous active-low reset
//   enable         : 0 forces filt to rst_val and clears the count
//   tick           : shared prescaler pulse
//   sync           : synchronised pad level
//   bypass         : 1 = skip debounce for this pad
//   rst_val        : filtered level at reset/disable (tied constant)
//   filt           : filtered level
// -----------------------------------------------------------------------------
module pad_debounce_bit
  import pad_cond_pkg::*;
#(
  parameter int unsigned DB_COUNT = 4
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic enable,
  input  logic tick,
  input  logic sync,
  input  logic bypass,
  input  logic rst_val,
  output logic filt
);

  localparam int unsigned   CW       = db_cnt_width(DB_COUNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      filt <= rst_val;
    end else if (!enable) begin
      cnt  <= '0;
      filt <= rst_val;
    end else if (bypass) begin
      cnt  <= '0;
      filt <= sync;
    end else if (sync == filt) begin
      cnt <= '0;
    end else if (tick) begin
      // Acceptance happens on the DB_COUNT-th differing tick, so the counter
      // never reaches DB_COUNT and cannot saturate.
      if (cnt == CNT_LAST) begin
        cnt  <= '0;
        filt <= sync;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pad_input_conditioner.sv
// -----------------------------------------------------------------------------
// pad_input_conditioner
// Input-side conditioning between the raw pads and the SoC UART RX / GPIO
// inputs. Every pad is synchronised; non-bypass pads are then debounced
// against a shared tick prescaler. The UART RX pad is synchronised only.
//
// Build option: define PAD_EDGE_IRQ_EN to add sticky any-edge capture with a
// maskable, registered interrupt. Without it edge_status_o and irq_o read 0,
// irq_mask_i / irq_clr_i are ignored and no edge flops exist.
//
// Ports:
//   sys_clk, rst_n  : clock, asynchronous active-low reset
//   enable_i        : 1 = pads routed to this IP; 0 holds the filter at RESET_VAL
//   pad_i           : raw asynchronous pad inputs
//   gpio_o          : filtered levels (the filter register itself)
//   uart_rx_o       : gpio_o[UART_PIN]
//   irq_mask_i      : per-pad interrupt enable
//   irq_clr_i       : write-1-to-clear pulses for edge_status_o
//   edge_status_o   : sticky edge flags
//   irq_o           : registered OR of edge_status_o & irq_mask_i
// -----------------------------------------------------------------------------
module pad_input_conditioner
  import pad_cond_pkg::*;
#(
  parameter int unsigned       WIDTH       = 16,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter int unsigned       TICK_DIV    = 1000,
  parameter int unsigned       DB_COUNT    = 4,
  parameter logic [WIDTH-1:0]  BYPASS_MASK = WIDTH'(16'h0001),
  parameter logic [WIDTH-1:0]  RESET_VAL   = WIDTH'(PAD_RESET_VAL),
  parameter int unsigned       UART_PIN    = PAD_UART_PIN
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic             uart_rx_o,
  input  logic [WIDTH-1:0] irq_mask_i,
  input  logic [WIDTH-1:0] irq_clr_i,
  output logic [WIDTH-1:0] edge_status_o,
  output logic             irq_o
);

  // ---------------------------------------------------------------------------
  // Synchronisers. They keep sampling while disabled so that re-enable starts
  // from a settled level.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the chain resets to RESET_VAL rather than 0 so the UART line
      // does not show a false start bit when reset is released.
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce tick prescaler: one pulse every TICK_DIV cycles while enabled.
  // ---------------------------------------------------------------------------
  localparam int unsigned   TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (!enable_i || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-pad filters.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] filt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    pad_debounce_bit #(
      .DB_COUNT (DB_COUNT)
    ) u_db (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .enable  (enable_i),
      .tick    (tick),
      .sync    (sync[i]),
      .bypass  (BYPASS_MASK[i]),
      .rst_val (RESET_VAL[i]),
      .filt    (filt[i])
    );
  end

  assign gpio_o    = filt;
  assign uart_rx_o = filt[UART_PIN];

  // ---------------------------------------------------------------------------
  // Sticky edge capture and interrupt.
  // ---------------------------------------------------------------------------
`ifdef PAD_EDGE_IRQ_EN
  logic [WIDTH-1:0] filt_prev;
  logic [WIDTH-1:0] edge_q;
  logic             irq_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_prev <= RESET_VAL;
      edge_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      irq_q <= |(edge_q & irq_mask_i);
      if (!enable_i) begin
        // filt is being forced to RESET_VAL too, so parking the history there
        // keeps the forced level from being reported as an edge on re-enable.
        filt_prev <= RESET_VAL;
        edge_q    <= '0;
      end else begin
        filt_prev <= filt;
        // Set term is OR-ed after the clear so a coincident set wins.
        edge_q    <= (filt ^ filt_prev) | (edge_q & ~irq_clr_i);
      end
    end
  end

  assign edge_status_o = edge_q;
  assign irq_o         = irq_q;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{irq_mask_i, irq_clr_i};

  assign edge_status_o = '0;
  assign irq_o         = 1'b0;
`endif

endmodule

// File: tb/tb_pad_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_pad_input_conditioner
// Directed scenarios with hand-computed expectations, followed by randomized
// pad/enable/clear/mask activity. A behavioural model tracks every cycle and
// a compare process checks all outputs at each falling edge.
// -----------------------------------------------------------------------------
module tb_pad_input_conditioner;
  import pad_cond_pkg::*;

  localparam int       TB_SYNC     = 2;
  localparam int       TB_TICK_DIV = 4;
  localparam int       TB_DB_COUNT = 3;
  localparam pad_vec_t TB_BYPASS   = 16'h0001;
  localparam pad_vec_t TB_RESET    = 16'h0001;
`ifdef PAD_EDGE_IRQ_EN
  localparam bit EDGE_ON = 1'b1;
`else
  localparam bit EDGE_ON = 1'b0;
`endif

  logic     sys_clk = 1'b0;
  logic     rst_n   = 1'b1;
  logic     enable_i;
  pad_vec_t pad_i;
  pad_vec_t gpio_o;
  logic     uart_rx_o;
  pad_vec_t irq_mask_i;
  pad_vec_t irq_clr_i;
  pad_vec_t edge_status_o;
  logic     irq_o;

  int n_checks = 0;
  int n_errors = 0;
  bit run_cmp  = 1'b0;

  always #5 sys_clk = ~sys_clk;

  pad_input_conditioner #(
    .WIDTH       (16),
    .SYNC_STAGES (TB_SYNC),
    .TICK_DIV    (TB_TICK_DIV),
    .DB_COUNT    (TB_DB_COUNT),
    .BYPASS_MASK (TB_BYPASS),
    .RESET_VAL   (TB_RESET),
    .UART_PIN    (0)
  ) dut (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .enable_i      (enable_i),
    .pad_i         (pad_i),
    .gpio_o        (gpio_o),
    .uart_rx_o     (uart_rx_o),
    .irq_mask_i    (irq_mask_i),
    .irq_clr_i     (irq_clr_i),
    .edge_status_o (edge_status_o),
    .irq_o         (irq_o)
  );

  // ---------------------------------------------------------------------------
  // Behavioural model.
  //   - the filter sees the pad value sampled TB_SYNC edges ago
  //   - ticks fall on every TB_TICK_DIV-th enabled edge since (re)enable
  //   - a debounced pad flips after TB_DB_COUNT consecutive differing ticks
  //   - edge flags record any filtered change, one cycle later
  // ---------------------------------------------------------------------------
  pad_vec_t m_hist [TB_SYNC];
  pad_vec_t m_filt, m_prev, m_stat;
  logic     m_irq;
  int       m_phase;
  int       m_runs [16];

  always @(posedge sys_clk or negedge rst_n) begin : model
    pad_vec_t seen;
    pad_vec_t nf;
    bit       tick;
    if (!rst_n) begin
      for (int s = 0; s < TB_SYNC; s++) m_hist[s] <= TB_RESET;
      for (int i = 0; i < 16; i++) m_runs[i] <= 0;
      m_filt  <= TB_RESET;
      m_prev  <= TB_RESET;
      m_stat  <= '0;
      m_irq   <= 1'b0;
      m_phase <= 0;
    end else begin
      seen = m_hist[TB_SYNC-1];
      for (int s = TB_SYNC - 1; s > 0; s--) m_hist[s] <= m_hist[s-1];
      m_hist[0] <= pad_i;
      if (EDGE_ON) m_irq <= |(m_stat & irq_mask_i);
      if (!enable_i) begin
        for (int i = 0; i < 16; i++) m_runs[i] <= 0;
        m_filt  <= TB_RESET;
        m_prev  <= TB_RESET;
        m_stat  <= '0;
        m_phase <= 0;
      end else begin
        tick = ((m_phase % TB_TICK_DIV) == TB_TICK_DIV - 1);
        m_phase <= m_phase + 1;
        nf = m_filt;
        for (int i = 0; i < 16; i++) begin
          if (TB_BYPASS[i]) begin
            nf[i] = seen[i];
          end else if (seen[i] == m_filt[i]) begin
            m_runs[i] <= 0;
          end else if (tick) begin
            if (m_runs[i] + 1 == TB_DB_COUNT) begin
              nf[i] = seen[i];
              m_runs[i] <= 0;
            end else begin
              m_runs[i] <= m_runs[i] + 1;
            end
          end
        end
        m_filt <= nf;
        m_prev <= m_filt;
        if (EDGE_ON) m_stat <= (m_filt ^ m_prev) | (m_stat & ~irq_clr_i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers.
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  always @(negedge sys_clk) begin
    if (run_cmp) begin
      check("model_gpio", gpio_o, m_filt);
      check("model_uart", uart_rx_o, m_filt[0]);
      check("model_edge", edge_status_o, m_stat);
      check("model_irq", irq_o, m_irq);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Waits for gpio_o[idx] to reach val; lat = edges waited, -1 on timeout.
  task automatic wait_bit(input int idx, input logic val, input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge sys_clk);
      if (gpio_o[idx] === val) begin
        lat = k;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus.
  // ---------------------------------------------------------------------------
  initial begin : stim
    int lat;
    int cnt;
    pad_i      = 16'hFFFF;
    enable_i   = 1'b1;
    irq_mask_i = 16'h0020;
    irq_clr_i  = '0;

    // Reset with all pads high.
    #2 rst_n = 1'b0;
    #1 run_cmp = 1'b1;
    step(2);
    check("rst_gpio", gpio_o, 16'h0001);
    check("rst_uart", uart_rx_o, 1'b1);
    check("rst_irq", irq_o, 1'b0);
    check("rst_edge", edge_status_o, 16'h0000);
    rst_n = 1'b1;
    step(1);
    check("post_rst_gpio_1", gpio_o, 16'h0001);
    step(1);
    check("post_rst_gpio_2", gpio_o, 16'h0001);

    // Clean restart with pads at idle.
    pad_i = 16'h0001;
    #2 rst_n = 1'b0;
    #1 check("async_rst_gpio", gpio_o, 16'h0001);
    step(1);
    rst_n = 1'b1;
    step(4);

    // Bypass latency and single-cycle pulse on the UART pad.
    pad_i[0] = 1'b0;
    step(2);
    check("bypass_before", uart_rx_o, 1'b1);
    step(1);
    check("bypass_latency", uart_rx_o, 1'b0);
    pad_i[0] = 1'b1;
    step(4);
    pad_i[0] = 1'b0;
    step(1);
    pad_i[0] = 1'b1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      if (uart_rx_o === 1'b0) cnt++;
    end
    check("bypass_pulse_width", cnt, 1);

    // Glitch shorter than one tick window is rejected.
    pad_i[5] = 1'b1;
    step(3);
    pad_i[5] = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (gpio_o[5] !== 1'b0) cnt++;
    end
    check("glitch_reject", cnt, 0);

    // Held level is accepted within the latency bound.
    pad_i[5] = 1'b1;
    wait_bit(5, 1'b1, 40, lat);
    check_range("accept_latency", lat, 11, 15);

    // Restart: the count restarts from the second rise.
    pad_i[5] = 1'b0;
    wait_bit(5, 1'b0, 40, lat);
    check_range("fall_latency", lat, 11, 15);
    step(2);
    pad_i[5] = 1'b1;
    step(7);
    pad_i[5] = 1'b0;
    step(1);
    check("restart_not_early", gpio_o[5], 1'b0);
    pad_i[5] = 1'b1;
    wait_bit(5, 1'b1, 40, lat);
    check_range("restart_latency", lat, 11, 15);

    // Edge capture, clear and set-wins.
    pad_i[5] = 1'b0;
    wait_bit(5, 1'b0, 40, lat);
    step(2);
    irq_clr_i = 16'hFFFF;
    step(1);
    irq_clr_i = '0;
    step(2);
    check("edge_cleared", edge_status_o, 16'h0000);
    check("irq_cleared", irq_o, 1'b0);
    pad_i[5] = 1'b1;
    wait_bit(5, 1'b1, 40, lat);
    check_range("edge_accept_latency", lat, 11, 15);
    step(1);
    check("edge_set", edge_status_o, EDGE_ON ? 16'h0020 : 16'h0000);
    step(1);
    check("irq_set", irq_o, EDGE_ON);
    irq_clr_i = 16'h0020;
    step(1);
    irq_clr_i = '0;
    check("edge_w1c", edge_status_o, 16'h0000);
    step(1);
    check("irq_after_clr", irq_o, 1'b0);
    pad_i[5] = 1'b0;
    wait_bit(5, 1'b0, 40, lat);
    irq_clr_i = 16'h0020;
    step(1);
    irq_clr_i = '0;
    check("edge_set_wins", edge_status_o, EDGE_ON ? 16'h0020 : 16'h0000);

    // Disable mid-debounce, then re-enable.
    pad_i = 16'h0200;
    step(20);
    check("pad9_accepted", gpio_o, 16'h0200);
    pad_i = 16'h0220;
    step(5);
    check("pad5_mid_debounce", gpio_o, 16'h0200);
    enable_i = 1'b0;
    step(1);
    check("disable_gpio", gpio_o, 16'h0001);
    check("disable_uart", uart_rx_o, 1'b1);
    check("disable_edge", edge_status_o, 16'h0000);
    step(3);
    enable_i = 1'b1;
    wait_bit(5, 1'b1, 40, lat);
    check_range("reenable_latency", lat, 11, 15);
    check("reenable_gpio", gpio_o, 16'h0220);

    // Randomized activity, with one asynchronous reset mid-run.
    for (int c = 0; c < 3000; c++) begin
      @(negedge sys_clk);
      if ($urandom_range(0, 99) < 10) pad_i[$urandom_range(0, 15)] ^= 1'b1;
      if (enable_i) begin
        if ($urandom_range(0, 199) == 0) enable_i = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        enable_i = 1'b1;
      end
      irq_clr_i = ($urandom_range(0, 15) == 0) ? pad_vec_t'($urandom) : '0;
      if ($urandom_range(0, 63) == 0) irq_mask_i = pad_vec_t'($urandom);
      if (c == 1500) begin
        #3 rst_n = 1'b0;
        #1;
        check("rand_rst_gpio", gpio_o, 16'h0001);
        check("rand_rst_edge", edge_status_o, 16'h0000);
        check("rand_rst_irq", irq_o, 1'b0);
        @(negedge sys_clk);
        rst_n = 1'b1;
      end
    end

    step(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
